fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
//
// PURPOSE
//   Program-counter / fetch stage directly upstream of the control decoder. Holds the PC
//   that addresses the instruction ROM and sequences program start, run and halt.
//   Consumes the decoder's BranchEn / Jump / Ack outputs plus the ALU condition flag to
//   select the next PC. Raises Done to the testbench when a program finishes.
//
// PARAMETERS
//   PC_W        10   width of ProgCtr and Target (instruction ROM depth = 2**PC_W)
//   START_ADDR  0    PC value loaded at reset and on each new Start
//   CNT_W       16   width of the run-cycle counter
//
// PORTS
//   Clk        in   1      clock, all state updates on rising edge
//   Reset      in   1      synchronous, active-low reset
//   Start      in   1      program request from testbench (level)
//   BranchEn   in   1      decoder: current instr is a conditional absolute branch
//   Jump       in   1      decoder: current instr is set-and-skip (sne/seq)
//   Ack        in   1      decoder: current instr is the halt word
//   CondFlag   in   1      ALU condition result for the current instr
//   Target     in   PC_W   branch target from branch LUT, valid when BranchEn=1
//   ProgCtr    out  PC_W   address to instruction ROM
//   Running    out  1      1 = ROM output at ProgCtr is a live instruction
//   Done       out  1      1 = program halted, result valid
//   CycleCt    out  CNT_W  cycles spent in RUN for the current/last program
//
// BEHAVIOUR
//   States: IDLE, RUN, HALT (registered, one-hot or binary free choice).
//   Reset (Reset=0 at edge): state=IDLE, ProgCtr=START_ADDR, CycleCt=0, Done=0, Running=0.
//   Running = (state==RUN); Done = (state==HALT); both decoded from state, no extra latency.
//   IDLE: ProgCtr held at START_ADDR, CycleCt held at 0. Start=1 keeps IDLE.
//     Start=0 while in IDLE and a Start=1 cycle has been seen since entry -> RUN next edge.
//     (Start is an arm-then-release pulse; Start low continuously never leaves IDLE.)
//   RUN: one instruction per cycle. Next PC, priority high->low:
//     1. Ack=1                    -> PC held, state -> HALT
//     2. BranchEn=1 & CondFlag=1  -> PC = Target
//     3. Jump=1 & CondFlag=1      -> PC = PC+2 (skip next instr)
//     4. otherwise                -> PC = PC+1
//     BranchEn with CondFlag=0 and Jump with CondFlag=0 fall to rule 4.
//     Inputs BranchEn/Jump/Ack/CondFlag are ignored outside RUN.
//   Arithmetic: PC+1 and PC+2 computed modulo 2**PC_W (wrap to 0 / 1, no flag).
//   CycleCt: +1 each RUN cycle including the Ack cycle; saturates at 2**CNT_W-1.
//   HALT: PC and CycleCt frozen. Start=1 -> IDLE next edge, ProgCtr=START_ADDR, CycleCt=0,
//     and that Start=1 cycle counts as the arm for the IDLE->RUN release.
//   Start=1 during RUN: ignored (no restart mid-program).
//   Reset=0 in any state overrides everything above on that edge.
//   Latency: PC update is visible one cycle after the instr that caused it; no stalls.
//
// TESTING
//   1. Reset=0 2 cycles, release; Start 1 for 3 cycles then 0 -> IDLE until release,
//      Running=1 next cycle with ProgCtr=0, then 1,2,3 on successive cycles.
//   2. In RUN at PC=5: BranchEn=1,CondFlag=1,Target=40 -> PC=40; same with CondFlag=0 -> PC=6.
//   3. At PC=7: Jump=1,CondFlag=1 -> PC=9; Jump=1,BranchEn=1,CondFlag=1,Target=3 -> PC=3.
//   4. PC_W=4, run from 14 via branch: PC 14->15->0; Jump taken at 15 -> 1 (wrap).
//   5. Ack=1 at PC=12 after 13 RUN cycles -> Done=1, ProgCtr stays 12, CycleCt=13 held;
//      Ack with BranchEn=1,CondFlag=1 same cycle -> still halts, PC=12.
//   6. Reset=0 mid-RUN at PC=20 -> next edge IDLE, ProgCtr=0, CycleCt=0, Done=0;
//      Start high in HALT then low -> fresh run from 0 with CycleCt restarting at 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Program-counter / fetch stage: sequences program start, run and halt, and picks
// the next instruction address from the decoder's branch/skip/halt indications.
//
// state  | meaning
// S_IDLE | waiting for Start arm-then-release; PC parked at START_ADDR, count cleared
// S_RUN  | one live instruction per cycle at ProgCtr; count advances every cycle
// S_HALT | program finished; PC and count frozen until Start re-arms
module fetch_unit #(
  parameter int              PC_W       = 10,
  parameter logic [PC_W-1:0] START_ADDR = '0,
  parameter int              CNT_W      = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BranchEn,
  input  logic             Jump,
  input  logic             Ack,
  input  logic             CondFlag,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic              armed, armed_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic [CNT_W-1:0]  cnt_nxt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state   <= S_IDLE;
      armed   <= 1'b0;
      ProgCtr <= START_ADDR;
      CycleCt <= '0;
    end else begin
      state   <= state_nxt;
      armed   <= armed_nxt;
      ProgCtr <= pc_nxt;
      CycleCt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    armed_nxt = armed;
    pc_nxt    = ProgCtr;
    cnt_nxt   = CycleCt;
    case (state)
      S_IDLE: begin
        pc_nxt  = START_ADDR;
        cnt_nxt = '0;
        if (Start) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          armed_nxt = 1'b0;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // The halt word itself is counted as a run cycle.
        if (CycleCt != CNT_MAX) cnt_nxt = CycleCt + CNT_W'(1);
        if (Ack)                       state_nxt = S_HALT;
        else if (BranchEn && CondFlag) pc_nxt = Target;
        else if (Jump && CondFlag)     pc_nxt = ProgCtr + PC_W'(2);
        else                           pc_nxt = ProgCtr + PC_W'(1);
      end
      S_HALT: begin
        // The Start that leaves HALT also arms the next IDLE->RUN release.
        if (Start) begin
          state_nxt = S_IDLE;
          armed_nxt = 1'b1;
          pc_nxt    = START_ADDR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        armed_nxt = 1'b0;
      end
    endcase
  end

  assign Running = (state == S_RUN);
  assign Done    = (state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then randomized traffic,
// checked every cycle against a behavioural program-sequencing model.
module tb_fetch_unit;

  localparam int PC_W    = 10;
  localparam int CNT_W   = 6;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset, start, branch_en, jump, ack, cond_flag;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  prog_ctr;
  logic             running, done;
  logic [CNT_W-1:0] cycle_ct;

  fetch_unit #(.PC_W(PC_W), .START_ADDR('0), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset(reset), .Start(start), .BranchEn(branch_en), .Jump(jump),
    .Ack(ack), .CondFlag(cond_flag), .Target(target),
    .ProgCtr(prog_ctr), .Running(running), .Done(done), .CycleCt(cycle_ct)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    bit running;
    bit done;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: program phase flags plus PC and cycle count as plain integers.
  bit m_running = 0, m_done = 0, m_armed = 0;
  int m_pc = 0, m_cnt = 0;

  task automatic model_step(input bit rs, st, br, jp, ak, cf, input int tgt);
    if (!rs) begin
      m_running = 0; m_done = 0; m_armed = 0; m_pc = 0; m_cnt = 0;
    end else if (m_running) begin
      m_cnt = (m_cnt + 1 > CNT_MAX) ? CNT_MAX : m_cnt + 1;
      if (ak) begin
        m_running = 0; m_done = 1;
      end else if (br && cf) m_pc = tgt % PC_MOD;
      else if (jp && cf)     m_pc = (m_pc + 2) % PC_MOD;
      else                   m_pc = (m_pc + 1) % PC_MOD;
    end else if (m_done) begin
      if (st) begin
        m_done = 0; m_pc = 0; m_cnt = 0; m_armed = 1;
      end
    end else begin
      if (st) m_armed = 1;
      else if (m_armed) begin
        m_armed = 0; m_running = 1;
      end
    end
  endtask

  task automatic drive(input bit rs, st, br, jp, ak, cf, input int tgt);
    exp_t e;
    reset = rs; start = st; branch_en = br; jump = jp; ack = ak; cond_flag = cf;
    target = PC_W'(tgt);
    model_step(rs, st, br, jp, ak, cf, tgt);
    e.pc = m_pc; e.running = m_running; e.done = m_done; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents ProgCtr/Running/Done/CycleCt for the last edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (prog_ctr !== PC_W'(e.pc) || running !== e.running ||
          done !== e.done || cycle_ct !== CNT_W'(e.cnt)) begin
        miscompares++;
        $display("FAIL vec%0d: got pc=%0d run=%0b done=%0b cnt=%0d, want pc=%0d run=%0b done=%0b cnt=%0d",
                 vectors, prog_ctr, running, done, cycle_ct, e.pc, e.running, e.done, e.cnt);
      end
    end
  end

  initial begin
    int wait_cnt;
    // Reset, then arm for 3 cycles and release: run from 0 counting up.
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    idle_cycles(3);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    idle_cycles(6);
    // Branch taken / not taken, skip, and branch-over-skip priority.
    drive(1, 0, 1, 0, 0, 1, 40);
    drive(1, 0, 1, 0, 0, 0, 77);
    drive(1, 0, 0, 1, 0, 1, 0);
    drive(1, 0, 0, 1, 0, 0, 0);
    drive(1, 0, 1, 1, 0, 1, 3);
    drive(1, 1, 0, 0, 0, 0, 0);
    // PC wrap at the top of the address space.
    drive(1, 0, 1, 0, 0, 1, PC_MOD - 2);
    idle_cycles(2);
    drive(1, 0, 1, 0, 0, 1, PC_MOD - 1);
    drive(1, 0, 0, 1, 0, 1, 0);
    // Halt beats a same-cycle taken branch; HALT ignores decoder inputs.
    drive(1, 0, 1, 0, 1, 1, 100);
    drive(1, 0, 1, 1, 0, 1, 50);
    drive(1, 0, 0, 0, 1, 0, 0);
    // Start in HALT re-arms; release gives a fresh run that saturates the count.
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0, 0);
    idle_cycles(CNT_MAX + 8);
    drive(1, 0, 0, 0, 1, 0, 0);
    idle_cycles(2);
    // Reset mid-run.
    drive(1, 1, 0, 0, 0, 0, 0);
    idle_cycles(22);
    drive(0, 1, 1, 0, 1, 1, 9);
    idle_cycles(3);
    drive(1, 1, 0, 0, 0, 0, 0);
    idle_cycles(4);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 149) != 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 24) == 0,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, PC_MOD - 1)));
    end
    wait_cnt = 0;
    while (sb.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    #6;
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending vectors, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
